sprite_row_fetch: RTL and testbench

Sprite ROM reader and line-buffered pixel source for the VGA draw path. Once per scanline, on a line-start pulse, it walks one row of a sprite ROM (10-bit address in, 24-bit palette colour out, combinational) into an internal line buffer. During active video it answers per-pixel queries from the colour mapper with a registered colour and an opaque flag. Pixels that match the transparent key (magenta) are never reported opaque.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_row_fetch_if.sv | 20 ++
 rtl/sprite_line_buf.sv | 50 +++++
 rtl/sprite_row_fetch.sv | 126 ++++++++++++
 tb/tb_sprite_row_fetch.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and line-buffer entry layout for the sprite row fetcher.
package sprite_pkg;

    localparam int          SPR_ROM_AW      = 10;
    localparam int          DEF_SPR_W       = 21;
    localparam int          DEF_SPR_H       = 41;
    localparam logic [23:0] TRANSPARENT_KEY = 24'h800080;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        opq;
        logic [23:0] color;
    } buf_entry_t;

    // Screen-coordinate difference widened to 11 bits so negatives are visible in bit 10.
    function automatic logic [10:0] diff11(input logic [9:0] a, input logic [9:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

endpackage

// File: rtl/sprite_row_fetch_if.sv
// ROM read port and per-pixel query port of the sprite row fetcher.
interface sprite_row_fetch_if #(
    parameter int ADDR_W = sprite_pkg::SPR_ROM_AW
);
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_color;
    logic [9:0]        DrawX;
    logic              pix_valid;
    logic [23:0]       pix_color;

    modport master (
        output rom_addr, pix_valid, pix_color,
        input  rom_color, DrawX
    );

    modport slave (
        input  rom_addr, pix_valid, pix_color,
        output rom_color, DrawX
    );
endinterface

// File: rtl/sprite_line_buf.sv
// One-row sprite line buffer: colour plus opaque flag per pixel, one write port,
// one registered read port that reports zero colour for out-of-range or transparent pixels.
module sprite_line_buf
    import sprite_pkg::*;
#(
    parameter int DEPTH = DEF_SPR_W,
    parameter int IDX_W = 5
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  buf_entry_t       wdata,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] raddr,
    output logic             rd_valid,
    output logic [23:0]      rd_color
);

    logic [23:0]      color_mem [DEPTH];
    logic [DEPTH-1:0] opq;
    logic             in_rng;
    logic             hit;

    // Colour storage needs no reset: a pixel is only ever reported through its opaque bit.
    always_ff @(posedge clk) begin
        if (we) color_mem[waddr] <= wdata.color;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     opq        <= '0;
        else if (we) opq[waddr] <= wdata.opq;
    end

    always_comb begin
        in_rng = rd_en && ({1'b0, raddr} < (IDX_W + 1)'(DEPTH));
        hit    = in_rng && opq[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_color <= '0;
        end else begin
            rd_valid <= hit;
            rd_color <= hit ? color_mem[raddr] : 24'h0;
        end
    end

endmodule

// File: rtl/sprite_row_fetch.sv
// Per-scanline sprite ROM row fetch into a line buffer, plus the 1-cycle pixel query path
// used by the colour mapper during active video.
module sprite_row_fetch
    import sprite_pkg::*;
#(
    parameter int          SPR_W       = DEF_SPR_W,
    parameter int          SPR_H       = DEF_SPR_H,
    parameter int          ADDR_W      = SPR_ROM_AW,
    parameter logic [23:0] TRANSPARENT = TRANSPARENT_KEY
)(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       line_start,
    input  logic [9:0] DrawY,
    input  logic [9:0] SpriteX,
    input  logic [9:0] SpriteY,
    input  logic       flip,
    output logic       busy,
    output logic       line_valid,
    sprite_row_fetch_if.master bus
);

    localparam int IDX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int PW    = 10 + $clog2(SPR_W + 1);
    localparam logic signed [10:0] W_S  = 11'(SPR_W);
    localparam logic signed [10:0] H_S  = 11'(SPR_H);
    localparam logic [IDX_W-1:0]   LAST = IDX_W'(SPR_W - 1);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [IDX_W-1:0]  wr_idx, wr_idx_n;
    logic              lv_n;
    logic [9:0]        sx_l;
    logic              flip_l;

    logic signed [10:0] row, rel;
    logic               row_hit;
    logic [PW-1:0]      row_base, start_addr;
    logic               buf_we;
    logic               rd_en;
    logic [IDX_W-1:0]   raddr;
    buf_entry_t         wentry;

    // Row base is formed at full product width; only the final sum is narrowed to the ROM bus.
    always_comb begin
        row        = signed'(diff11(DrawY, SpriteY));
        row_hit    = !row[10] && (row < H_S);
        row_base   = PW'(row[9:0]) * PW'(SPR_W);
        start_addr = row_base + (flip ? PW'(SPR_W - 1) : PW'(0));
    end

    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        wr_idx_n = wr_idx;
        lv_n     = line_valid;
        buf_we   = 1'b0;
        if (line_start) begin
            // A new line always wins, including over a fetch still in flight.
            lv_n     = 1'b0;
            wr_idx_n = '0;
            if (row_hit) begin
                state_n = FETCH;
                addr_n  = ADDR_W'(start_addr);
            end else begin
                state_n = IDLE;
            end
        end else if (state == FETCH) begin
            buf_we = 1'b1;
            if (wr_idx == LAST) begin
                state_n = IDLE;
                lv_n    = 1'b1;
            end else begin
                wr_idx_n = wr_idx + IDX_W'(1);
                addr_n   = flip_l ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wr_idx     <= '0;
            line_valid <= 1'b0;
            sx_l       <= '0;
            flip_l     <= 1'b0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            wr_idx     <= wr_idx_n;
            line_valid <= lv_n;
            if (line_start) begin
                sx_l   <= SpriteX;
                flip_l <= flip;
            end
        end
    end

    assign busy         = (state == FETCH);
    assign bus.rom_addr = addr_q;

    always_comb begin
        wentry.color = bus.rom_color;
        wentry.opq   = (bus.rom_color != TRANSPARENT);
        rel          = signed'(diff11(bus.DrawX, sx_l));
        rd_en        = line_valid && !rel[10] && (rel < W_S);
        raddr        = rel[IDX_W-1:0];
    end

    sprite_line_buf #(
        .DEPTH (SPR_W),
        .IDX_W (IDX_W)
    ) u_line_buf (
        .clk      (Clk),
        .rst      (Reset),
        .we       (buf_we),
        .waddr    (wr_idx),
        .wdata    (wentry),
        .rd_en    (rd_en),
        .raddr    (raddr),
        .rd_valid (bus.pix_valid),
        .rd_color (bus.pix_color)
    );

endmodule

// File: tb/tb_sprite_row_fetch.sv
// Directed bench for sprite_row_fetch: ROM returns {14'h0, addr}, address 42 is the transparent key.
module tb_sprite_row_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       line_start;
    logic       flip;
    logic [9:0] DrawY, SpriteX, SpriteY;
    logic       busy, line_valid;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_row_fetch_if #(.ADDR_W(10)) bus ();

    assign bus.rom_color = (bus.rom_addr == 10'd42) ? 24'h800080 : {14'h0, bus.rom_addr};

    sprite_row_fetch dut (
        .Clk        (clk),
        .Reset      (rst),
        .line_start (line_start),
        .DrawY      (DrawY),
        .SpriteX    (SpriteX),
        .SpriteY    (SpriteY),
        .flip       (flip),
        .busy       (busy),
        .line_valid (line_valid),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [9:0] dy, input logic fl);
        @(negedge clk);
        DrawY      = dy;
        flip       = fl;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    // Called right after the line_start edge: checks the address walk and line_valid timing.
    task automatic walk(input string tag, input int start, input int dir);
        for (int k = 0; k < 21; k++) begin
            chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(start + dir * k));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_lv_early"}, 32'(line_valid), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_lv_done"}, 32'(line_valid), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic query(input string tag, input logic [9:0] x, input logic v, input logic [23:0] c);
        bus.DrawX = x;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.pix_valid), 32'(v));
        chk({tag, "_color"}, 32'(bus.pix_color), 32'(c));
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd0);
            chk({tag, "_lv"}, 32'(line_valid), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, 32'(bus.rom_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_lv"}, 32'(line_valid), 32'd0);
        chk({tag, "_pv"}, 32'(bus.pix_valid), 32'd0);
        chk({tag, "_pc"}, 32'(bus.pix_color), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        line_start = 1'b0;
        flip       = 1'b0;
        DrawY      = 10'd0;
        SpriteX    = 10'd100;
        SpriteY    = 10'd200;
        bus.DrawX  = 10'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Row 2, unflipped: base 42, buf[k] = 42+k, buf[0] transparent.
        pulse(10'd202, 1'b0);
        walk("fwd", 42, 1);
        query("fwd_x100", 10'd100, 1'b0, 24'h0);
        query("fwd_x101", 10'd101, 1'b1, 24'h00002B);
        query("fwd_x120", 10'd120, 1'b1, 24'h00003E);
        query("fwd_x121", 10'd121, 1'b0, 24'h0);
        query("fwd_x99",  10'd99,  1'b0, 24'h0);
        chk("fwd_lv_hold", 32'(line_valid), 32'd1);

        // Row 2, flipped: buf[k] = 62-k, buf[20] transparent.
        pulse(10'd202, 1'b1);
        walk("flip", 62, -1);
        query("flip_x100", 10'd100, 1'b1, 24'h00003E);
        query("flip_x101", 10'd101, 1'b1, 24'h00003D);
        query("flip_x120", 10'd120, 1'b0, 24'h0);
        SpriteX = 10'd50;
        query("flip_sx_latched", 10'd100, 1'b1, 24'h00003E);
        SpriteX = 10'd100;

        // Rows outside the sprite.
        pulse(10'd199, 1'b0);
        quiet("miss199", 25);
        query("miss199_x101", 10'd101, 1'b0, 24'h0);
        pulse(10'd241, 1'b0);
        quiet("miss241", 25);

        // Restart mid-fetch with row 3: base 63.
        pulse(10'd202, 1'b0);
        repeat (4) @(negedge clk);
        chk("restart_lv_mid", 32'(line_valid), 32'd0);
        pulse(10'd203, 1'b0);
        walk("restart", 63, 1);
        query("restart_x100", 10'd100, 1'b1, 24'h00003F);
        query("restart_x120", 10'd120, 1'b1, 24'h000053);

        // Reset mid-fetch, then a clean fetch.
        pulse(10'd202, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        chk_reset_vals("midrst_hold");
        rst = 1'b0;
        pulse(10'd202, 1'b0);
        walk("post", 42, 1);
        query("post_x100", 10'd100, 1'b0, 24'h0);
        query("post_x101", 10'd101, 1'b1, 24'h00002B);
        query("post_x110", 10'd110, 1'b1, 24'h000034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
